// File: rtl/pixel_engine_scheduler_if.sv
// pixel_engine_scheduler_if: engine dispatch/completion and raster pixel output bundle
interface pixel_engine_scheduler_if #(
   parameter int NUM_ENGINES = 4,
   parameter int ITER_W      = 8
);
   logic [NUM_ENGINES-1:0]        eng_start;
   logic [15:0]                   eng_x;
   logic [15:0]                   eng_y;
   logic                          eng_mode;
   logic [NUM_ENGINES-1:0]        eng_done;
   logic [NUM_ENGINES*ITER_W-1:0] eng_iter;
   logic                          pix_valid;
   logic                          pix_ready;
   logic [ITER_W-1:0]             pix_iter;
   logic                          pix_sof;
   logic                          pix_eol;
   modport master (
      output eng_start, eng_x, eng_y, eng_mode, pix_valid, pix_iter, pix_sof, pix_eol,
      input  eng_done, eng_iter, pix_ready
   );
   modport slave (
      input  eng_start, eng_x, eng_y, eng_mode, pix_valid, pix_iter, pix_sof, pix_eol,
      output eng_done, eng_iter, pix_ready
   );
endinterface

// File: rtl/pixel_engine_scheduler.sv
// pixel_engine_scheduler: round-robin pixel dispatch to engines with in-order result retire; SCHED_PERF_EN adds frame/stall counters
module pixel_engine_scheduler #(
   parameter int NUM_ENGINES = 4,
   parameter int X_SIZE      = 640,
   parameter int Y_SIZE      = 480,
   parameter int ITER_W      = 8
) (
   input  logic                      out_stream_aclk,
   input  logic                      periph_reset,
   input  logic                      cfg_run,
   input  logic                      cfg_mode,
   pixel_engine_scheduler_if.master  bus,
   output logic                      sched_err
`ifdef SCHED_PERF_EN
   ,
   output logic [31:0]               perf_frame_cycles,
   output logic [31:0]               perf_stall_cycles
`endif
);
   localparam int PW = NUM_ENGINES > 1 ? $clog2(NUM_ENGINES) : 1;
   localparam logic [PW-1:0] PL = PW'(NUM_ENGINES - 1);
   localparam logic [15:0] XL = 16'(X_SIZE - 1);
   localparam logic [15:0] YL = 16'(Y_SIZE - 1);
   localparam logic [NUM_ENGINES-1:0] ONE = NUM_ENGINES'(1);
   typedef enum logic [1:0] {F_IDLE, F_RUN, F_DRAIN} frame_t;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} slot_t;
   frame_t            state, state_nx;
   slot_t             slot [NUM_ENGINES];
   logic [ITER_W-1:0] result [NUM_ENGINES];
   logic [PW-1:0]     d, r;
   logic [15:0]       dx, dy, ox, oy;
   logic              dispatch, retire, last_disp, last_ret;
   assign dispatch      = state == F_RUN && slot[d] == S_IDLE;
   assign last_disp     = dx == XL && dy == YL;
   assign retire        = bus.pix_valid && bus.pix_ready;
   assign last_ret      = ox == XL && oy == YL;
   assign bus.pix_valid = slot[r] == S_DONE;
   assign bus.pix_iter  = result[r];
   assign bus.pix_sof   = ox == 16'd0 && oy == 16'd0;
   assign bus.pix_eol   = ox == XL;
   // frame state register
   always_ff @(posedge out_stream_aclk)
      state <= periph_reset ? F_IDLE : state_nx;
   // frame sequencing: run until the last pixel is dispatched, drain until it is retired
   always_comb begin
      state_nx = state;
      case (state)
         F_IDLE:  state_nx = cfg_run ? F_RUN : F_IDLE;
         F_RUN:   state_nx = dispatch && last_disp ? F_DRAIN : F_RUN;
         F_DRAIN: state_nx = retire && last_ret ? F_IDLE : F_DRAIN;
         default: state_nx = F_IDLE;
      endcase
   end
   // dispatch: registered start pulse with coordinates, mode latched once per frame
   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         bus.eng_start <= '0;
         bus.eng_x     <= '0;
         bus.eng_y     <= '0;
         bus.eng_mode  <= 1'b0;
         d             <= '0;
         dx            <= '0;
         dy            <= '0;
      end else begin
         bus.eng_start <= dispatch ? ONE << d : '0;
         if (state == F_IDLE && cfg_run) bus.eng_mode <= cfg_mode;
         if (dispatch) begin
            bus.eng_x <= dx;
            bus.eng_y <= dy;
            d         <= d == PL ? '0 : d + 1'b1;
            dx        <= dx == XL ? '0 : dx + 16'd1;
            dy        <= dx == XL ? (dy == YL ? '0 : dy + 16'd1) : dy;
         end
      end
   end
   // retire pointer and output raster position advance on each accepted pixel
   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         r  <= '0;
         ox <= '0;
         oy <= '0;
      end else if (retire) begin
         r  <= r == PL ? '0 : r + 1'b1;
         ox <= ox == XL ? '0 : ox + 16'd1;
         oy <= ox == XL ? (oy == YL ? '0 : oy + 16'd1) : oy;
      end
   end
   // per-slot lifecycle; a done pulse on a slot that is not busy is flagged and otherwise ignored
   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         for (int i = 0; i < NUM_ENGINES; i++) slot[i] <= S_IDLE;
         sched_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_ENGINES; i++) begin
            if (dispatch && d == PW'(i)) slot[i] <= S_BUSY;
            else if (retire && r == PW'(i)) slot[i] <= S_IDLE;
            else if (bus.eng_done[i] && slot[i] == S_BUSY) begin
               slot[i]   <= S_DONE;
               result[i] <= bus.eng_iter[i*ITER_W +: ITER_W];
            end
            if (bus.eng_done[i] && slot[i] != S_BUSY) sched_err <= 1'b1;
         end
      end
   end
`ifdef SCHED_PERF_EN
   logic [31:0] frame_cnt, stall_cnt;
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return &v ? v : v + 32'd1;
   endfunction
   // frame and stall cycle counters, published when a frame finishes draining
   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         frame_cnt         <= '0;
         stall_cnt         <= '0;
         perf_frame_cycles <= '0;
         perf_stall_cycles <= '0;
      end else if (state == F_IDLE) begin
         frame_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         frame_cnt <= sat_inc(frame_cnt);
         if (state == F_RUN && slot[d] != S_IDLE) stall_cnt <= sat_inc(stall_cnt);
         if (state == F_DRAIN && state_nx == F_IDLE) begin
            perf_frame_cycles <= sat_inc(frame_cnt);
            perf_stall_cycles <= stall_cnt;
         end
      end
   end
`endif
endmodule

// File: tb/tb_pixel_engine_scheduler.sv
// tb_pixel_engine_scheduler: directed scenarios with engine latency models and raster-order stream checks
module tb_pixel_engine_scheduler;
   localparam int NE = 4, XS = 8, YS = 4, IW = 8, NPIX = XS * YS;
   logic clk = 1'b0, rst = 1'b1, cfg_run = 1'b0, cfg_mode = 1'b0, sched_err;
   logic [NE-1:0] model_done = '0, inj = '0;
   logic [NE*IW-1:0] model_iter = '0;
   int checks = 0, errors = 0;
   int lat [NE];
   int cnt [NE];
   logic [IW-1:0] pend [NE];
   time t_done0 = 0, t_valid = 0;
   logic [IW-1:0] q_iter [$];
   logic q_sof [$];
   logic q_eol [$];
   logic [NE-1:0] d_start [$];
   logic [15:0] d_x [$];
   logic [15:0] d_y [$];
   logic d_mode [$];

   pixel_engine_scheduler_if #(.NUM_ENGINES(NE), .ITER_W(IW)) bus ();
   assign bus.eng_done = model_done | inj;
   assign bus.eng_iter = model_iter;

   pixel_engine_scheduler #(.NUM_ENGINES(NE), .X_SIZE(XS), .Y_SIZE(YS), .ITER_W(IW)) dut (
      .out_stream_aclk(clk),
      .periph_reset(rst),
      .cfg_run(cfg_run),
      .cfg_mode(cfg_mode),
      .bus(bus),
      .sched_err(sched_err)
   );

   always #5 clk = ~clk;

   // engine models: fixed latency per engine, result encodes mode and raster index
   always @(negedge clk) begin
      for (int i = 0; i < NE; i++) begin
         model_done[i] = 1'b0;
         if (rst) cnt[i] = 0;
         else begin
            if (cnt[i] > 0) begin
               cnt[i] = cnt[i] - 1;
               if (cnt[i] == 0) begin
                  model_done[i] = 1'b1;
                  model_iter[i*IW +: IW] = pend[i];
                  if (i == 0 && t_done0 == 0) t_done0 = $time;
               end
            end
            if (bus.eng_start[i]) begin
               cnt[i] = lat[i];
               pend[i] = {bus.eng_mode, 7'(int'(bus.eng_y) * XS + int'(bus.eng_x))};
            end
         end
      end
   end

   // record accepted pixels and dispatches
   always @(negedge clk) begin
      if (bus.pix_valid && t_valid == 0) t_valid = $time;
      if (bus.pix_valid && bus.pix_ready) begin
         q_iter.push_back(bus.pix_iter);
         q_sof.push_back(bus.pix_sof);
         q_eol.push_back(bus.pix_eol);
      end
      if (|bus.eng_start) begin
         d_start.push_back(bus.eng_start);
         d_x.push_back(bus.eng_x);
         d_y.push_back(bus.eng_y);
         d_mode.push_back(bus.eng_mode);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_iter.delete(); q_sof.delete(); q_eol.delete();
      d_start.delete(); d_x.delete(); d_y.delete(); d_mode.delete();
      t_done0 = 0;
      t_valid = 0;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1; cfg_run = 1'b0; cfg_mode = 1'b0; inj = '0;
      tick();
      tick();
      rst = 1'b0;
      clear_q();
   endtask

   task automatic start_frame();
      cfg_run = 1'b1;
      tick();
      cfg_run = 1'b0;
   endtask

   task automatic wait_pix(input int n, output bit ok);
      for (int b = 0; b < 3000 && q_iter.size() < n; b++) @(negedge clk);
      ok = q_iter.size() >= n;
   endtask

   task automatic wait_disp(input int n, output bit ok);
      for (int b = 0; b < 3000 && d_x.size() < n; b++) @(negedge clk);
      ok = d_x.size() >= n;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.pix_ready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (bus.eng_start !== '0 || bus.eng_x !== 16'd0 || bus.eng_y !== 16'd0 || bus.eng_mode !== 1'b0)
         begin errors++; $display("FAIL reset_eng start=%b x=%0d y=%0d mode=%b want 0000 0 0 0", bus.eng_start, bus.eng_x, bus.eng_y, bus.eng_mode); end
      checks++;
      if (bus.pix_valid !== 1'b0 || sched_err !== 1'b0)
         begin errors++; $display("FAIL reset_out pix_valid=%b sched_err=%b want 0 0", bus.pix_valid, sched_err); end
      checks++;
      if (bus.pix_sof !== 1'b1 || bus.pix_eol !== 1'b0)
         begin errors++; $display("FAIL reset_pos sof=%b eol=%b want 1 0", bus.pix_sof, bus.pix_eol); end
   endtask

   task automatic test_basic();
      bit ok;
      lat = '{5, 5, 5, 5};
      do_reset();
      bus.pix_ready = 1'b1;
      start_frame();
      wait_pix(NPIX, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout pixels=%0d want %0d", q_iter.size(), NPIX); end
      repeat (40) @(negedge clk);
      checks++;
      if (d_x.size() != NPIX) begin errors++; $display("FAIL basic_dispatch_count got %0d want %0d", d_x.size(), NPIX); end
      for (int i = 0; i < NE && i < d_x.size(); i++) begin
         checks++;
         if (d_start[i] !== (4'b0001 << i) || d_x[i] !== 16'(i) || d_y[i] !== 16'd0 || d_mode[i] !== 1'b0)
            begin errors++; $display("FAIL basic_dispatch i=%0d start=%b x=%0d y=%0d mode=%b want %b %0d 0 0", i, d_start[i], d_x[i], d_y[i], d_mode[i], 4'b0001 << i, i); end
      end
      for (int k = 0; k < q_iter.size(); k++) begin
         checks++;
         if (q_iter[k] !== IW'(k) || q_sof[k] !== (k == 0) || q_eol[k] !== (k % XS == XS - 1))
            begin errors++; $display("FAIL basic_pix k=%0d iter=%0d sof=%b eol=%b want %0d %b %b", k, q_iter[k], q_sof[k], q_eol[k], k, k == 0, k % XS == XS - 1); end
      end
   endtask

   task automatic test_latency();
      bit ok;
      lat = '{40, 3, 17, 9};
      do_reset();
      bus.pix_ready = 1'b1;
      start_frame();
      wait_pix(NPIX, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lat_timeout pixels=%0d want %0d", q_iter.size(), NPIX); end
      checks++;
      if (t_done0 == 0 || t_valid <= t_done0)
         begin errors++; $display("FAIL lat_first_valid valid_t=%0t done0_t=%0t want valid after done0", t_valid, t_done0); end
      for (int k = 0; k < q_iter.size(); k++) begin
         checks++;
         if (q_iter[k] !== IW'(k))
            begin errors++; $display("FAIL lat_order k=%0d iter=%0d want %0d", k, q_iter[k], k); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [IW-1:0] hold;
      lat = '{5, 5, 5, 5};
      do_reset();
      bus.pix_ready = 1'b0;
      start_frame();
      for (int b = 0; b < 500 && !bus.pix_valid; b++) @(negedge clk);
      checks++;
      if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid pix_valid=%b want 1", bus.pix_valid); end
      hold = bus.pix_iter;
      checks++;
      if (hold !== '0) begin errors++; $display("FAIL bp_first_iter iter=%0d want 0", hold); end
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         checks++;
         if (bus.pix_valid !== 1'b1 || bus.pix_iter !== hold)
            begin errors++; $display("FAIL bp_hold cycle=%0d valid=%b iter=%0d want 1 %0d", c, bus.pix_valid, bus.pix_iter, hold); end
      end
      checks++;
      if (d_x.size() != NE) begin errors++; $display("FAIL bp_in_flight got %0d want %0d", d_x.size(), NE); end
      tick();
      bus.pix_ready = 1'b1;
      wait_pix(NPIX, ok);
      repeat (40) @(negedge clk);
      checks++;
      if (q_iter.size() != NPIX || d_x.size() != NPIX)
         begin errors++; $display("FAIL bp_counts pixels=%0d dispatches=%0d want %0d %0d", q_iter.size(), d_x.size(), NPIX, NPIX); end
      for (int k = 0; k < q_iter.size(); k++) begin
         checks++;
         if (q_iter[k] !== IW'(k))
            begin errors++; $display("FAIL bp_order k=%0d iter=%0d want %0d", k, q_iter[k], k); end
      end
   endtask

   task automatic test_mode_change();
      bit ok;
      lat = '{5, 5, 5, 5};
      do_reset();
      bus.pix_ready = 1'b1;
      cfg_run = 1'b1;
      wait_disp(10, ok);
      cfg_mode = 1'b1;
      wait_disp(NPIX + 1, ok);
      cfg_run = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL mode_second_frame dispatches=%0d want >%0d", d_x.size(), NPIX); end
      wait_pix(2 * NPIX, ok);
      repeat (40) @(negedge clk);
      checks++;
      if (d_x.size() != 2 * NPIX || q_iter.size() != 2 * NPIX)
         begin errors++; $display("FAIL mode_counts dispatches=%0d pixels=%0d want %0d %0d", d_x.size(), q_iter.size(), 2 * NPIX, 2 * NPIX); end
      for (int k = 0; k < d_x.size(); k++) begin
         checks++;
         if (d_mode[k] !== (k >= NPIX))
            begin errors++; $display("FAIL mode_dispatch k=%0d mode=%b want %b", k, d_mode[k], k >= NPIX); end
      end
      if (d_x.size() > NPIX) begin
         checks++;
         if (d_start[NPIX] !== 4'b0001 || d_x[NPIX] !== 16'd0 || d_y[NPIX] !== 16'd0)
            begin errors++; $display("FAIL mode_frame2_start start=%b x=%0d y=%0d want 0001 0 0", d_start[NPIX], d_x[NPIX], d_y[NPIX]); end
      end
      for (int k = 0; k < q_iter.size(); k++) begin
         checks++;
         if (q_iter[k] !== {k >= NPIX, 7'(k % NPIX)} || q_sof[k] !== (k % NPIX == 0))
            begin errors++; $display("FAIL mode_pix k=%0d iter=%0d sof=%b want %0d %b", k, q_iter[k], q_sof[k], {k >= NPIX, 7'(k % NPIX)}, k % NPIX == 0); end
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      lat = '{40, 40, 40, 40};
      do_reset();
      bus.pix_ready = 1'b1;
      cfg_run = 1'b1;
      wait_disp(3, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mrst_dispatch dispatches=%0d want 3", d_x.size()); end
      tick();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.pix_valid !== 1'b0 || bus.eng_start !== '0)
         begin errors++; $display("FAIL mrst_clear pix_valid=%b eng_start=%b want 0 0000", bus.pix_valid, bus.eng_start); end
      tick();
      rst = 1'b0;
      clear_q();
      wait_disp(1, ok);
      cfg_run = 1'b0;
      checks++;
      if (!ok || d_start[0] !== 4'b0001 || d_x[0] !== 16'd0 || d_y[0] !== 16'd0)
         begin errors++; $display("FAIL mrst_first ok=%b start=%b x=%0d y=%0d want 1 0001 0 0", ok, ok ? d_start[0] : 4'b0, ok ? d_x[0] : 16'd0, ok ? d_y[0] : 16'd0); end
      wait_pix(NPIX, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mrst_timeout pixels=%0d want %0d", q_iter.size(), NPIX); end
      for (int k = 0; k < q_iter.size(); k++) begin
         checks++;
         if (q_iter[k] !== IW'(k))
            begin errors++; $display("FAIL mrst_order k=%0d iter=%0d want %0d", k, q_iter[k], k); end
      end
      checks++;
      if (sched_err !== 1'b0) begin errors++; $display("FAIL mrst_err sched_err=%b want 0", sched_err); end
   endtask

   task automatic test_sched_err();
      bit ok;
      lat = '{5, 5, 5, 5};
      do_reset();
      bus.pix_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (sched_err !== 1'b0) begin errors++; $display("FAIL err_pre sched_err=%b want 0", sched_err); end
      tick();
      inj = 4'b0100;
      tick();
      inj = '0;
      @(negedge clk);
      checks++;
      if (sched_err !== 1'b1) begin errors++; $display("FAIL err_set sched_err=%b want 1", sched_err); end
      tick();
      start_frame();
      wait_pix(NPIX, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL err_timeout pixels=%0d want %0d", q_iter.size(), NPIX); end
      for (int k = 0; k < q_iter.size(); k++) begin
         checks++;
         if (q_iter[k] !== IW'(k) || q_eol[k] !== (k % XS == XS - 1))
            begin errors++; $display("FAIL err_stream k=%0d iter=%0d eol=%b want %0d %b", k, q_iter[k], q_eol[k], k, k % XS == XS - 1); end
      end
      checks++;
      if (sched_err !== 1'b1) begin errors++; $display("FAIL err_sticky sched_err=%b want 1", sched_err); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_backpressure();
      test_mode_change();
      test_mid_reset();
      test_sched_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
